cpu_mem_arbiter: RTL and testbench
==================================

// Module: cpu_mem_arbiter
// PURPOSE
//  Parametrised CPU memory controller: arbitrates NUM_CH request channels
//  (ch0 = data load/store, ch1 = instruction fetch, ch2+ = VPU/DMA) onto one
//  single-port synchronous RAM with fixed read latency. Zero-fills the RAM
//  after reset, then accepts at most one request/cycle, fully pipelined.
//  Responses are routed back to the originating channel.
// PARAMETERS
//  NUM_CH  2   request channels (1..8)
//  ADDR_W  16  word address width; RAM depth = 2**ADDR_W
//  DATA_W  32  data word width
//  RD_LAT  2   RAM read latency in cycles (1..4), mem_en to mem_rdata valid
// PORTS
//  clk        in   1              system clock, all logic on posedge
//  rst_n      in   1              synchronous active-low reset
//  req_valid  in   NUM_CH         per-channel request valid
//  req_ready  out  NUM_CH         per-channel accept; handshake = valid & ready
//  req_we     in   NUM_CH         1 = write, 0 = read
//  req_addr   in   NUM_CH*ADDR_W  packed addresses, ch0 in LSBs
//  req_wdata  in   NUM_CH*DATA_W  packed write data, ch0 in LSBs
//  rsp_valid  out  NUM_CH         one-cycle response strobe to owning channel
//  rsp_rdata  out  DATA_W         read data (0 for write acks), shared bus
//  mem_en     out  1              RAM access enable
//  mem_we     out  1              RAM write enable
//  mem_addr   out  ADDR_W         RAM address
//  mem_wdata  out  DATA_W         RAM write data
//  mem_rdata  in   DATA_W         RAM read data, valid RD_LAT cycles after mem_en
//  init_done  out  1              RAM zero-fill complete
// BEHAVIOUR
//  - Reset (rst_n low at posedge): state=INIT, fill counter=0, rr pointer=0,
//    response tag pipe cleared; all outputs 0.
//  - States: INIT -> RUN. INIT drives mem_en=1, mem_we=1, mem_wdata=0,
//    mem_addr=counter, counter++ each cycle; req_ready=0. On counter
//    wrapping at 2**ADDR_W-1 -> RUN, init_done=1 next cycle, stays 1.
//  - RUN: grant = one channel with req_valid; req_ready is combinational,
//    one-hot or zero. Accepted request drives mem_* in the SAME cycle
//    (mem_en=1, mem_we=req_we, addr/wdata of granted channel).
//  - Tag pipe depth RD_LAT carries {valid, we, ch}; every accepted request
//    yields rsp_valid[ch]=1 exactly RD_LAT cycles later. rsp_rdata =
//    mem_rdata for reads, 0 for writes. Responses in strict accept order.
//  - No stalls: RAM is fixed-latency, so the pipe never back-pressures;
//    up to RD_LAT requests in flight. Responses cannot be refused.
//  - Read-after-write same address, back-to-back: write cycle N, read N+1
//    returns new data (RAM write-first ordering is required of the RAM).
//  - Requester must hold valid/addr/wdata/we stable until ready.
//  - Reset mid-operation: in-flight responses dropped (no rsp_valid),
//    INIT re-runs; RAM contents are re-zeroed.
//  - Non-granted channels see req_ready=0 and must hold their request.
// CONFIGURATION
//  CPU_MEM_RR_EN defined: round-robin. Search starts at rr pointer; after a
//    grant to ch k pointer = (k+1) mod NUM_CH; pointer unchanged when idle.
//  CPU_MEM_RR_EN undefined: fixed priority, lowest index wins (ch0 highest);
//    no pointer register exists.
// TESTING (bench params ADDR_W=4, DATA_W=32, RD_LAT=2, NUM_CH=2)
//  1 Reset, hold requests high -> req_ready=0 for 16 cycles, mem_we=1 with
//    addr 0..15, init_done rises on cycle 17; read addr 5 -> rsp_rdata=0.
//  2 ch0 write addr 3 = 0xDEADBEEF, then ch0 read addr 3 next cycle ->
//    rsp_valid[0] at +2 each; second rsp_rdata=0xDEADBEEF.
//  3 Both channels read every cycle, RR_EN -> grants alternate 0,1,0,1;
//    without RR_EN -> ch0 granted every cycle, ch1 starved.
//  4 Back-to-back reads addr 1,2,3 on ch1 (preloaded 0x11,0x22,0x33) ->
//    rsp_valid[1] on 3 consecutive cycles, data 0x11,0x22,0x33 in order.
//  5 Assert rst_n=0 with 2 reads in flight -> no rsp_valid afterwards,
//    init_done=0, INIT sweep repeats, then RUN resumes normally.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// NUM_CH-channel arbiter onto one fixed-latency single-port RAM: zero-fills the RAM after reset, then issues one request per cycle.
// Define CPU_MEM_RR_EN for round-robin grant; the default is fixed priority with ch0 highest.

module cpu_mem_arb_lane #(
  parameter int CW   = 1,
  parameter int LANE = 0
) (
  input  logic          accept,
  input  logic [CW-1:0] gnt_ch,
  input  logic          tag_vld,
  input  logic [CW-1:0] tag_ch,
  output logic          ready,
  output logic          rsp
);
  assign ready = accept && (gnt_ch == CW'(LANE));
  assign rsp   = tag_vld && (tag_ch == CW'(LANE));
endmodule

module cpu_mem_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     init_done
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {INIT, RUN} state_t;
  typedef struct packed {
    logic          we;
    logic [CW-1:0] ch;
  } tag_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic                run, any, accept;
  logic [CW-1:0]       gnt_ch;
  logic [RD_LAT:1]     vld_pipe;
  tag_t [RD_LAT:1]     tag_pipe;

  assign run    = (state == RUN);
  assign accept = run && any;

`ifdef CPU_MEM_RR_EN
  logic [CW-1:0] rr_ptr;

  always_comb begin
    int j;
    any    = 1'b0;
    gnt_ch = '0;
    j      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!any && req_valid[j]) begin
        any    = 1'b1;
        gnt_ch = CW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      rr_ptr <= '0;
    else if (accept) rr_ptr <= (int'(gnt_ch) == NUM_CH - 1) ? '0 : gnt_ch + 1'b1;
  end
`else
  // Descending scan so the lowest valid index is the last (winning) write.
  always_comb begin
    any    = 1'b0;
    gnt_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any    = 1'b1;
        gnt_ch = CW'(i);
      end
    end
  end
`endif

  // Fill writes are held off while rst_n is low so the RAM sees no traffic in reset.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!run) begin
      if (rst_n) begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = cnt;
      end
    end else if (accept) begin
      mem_en    = 1'b1;
      mem_we    = req_we[gnt_ch];
      mem_addr  = req_addr[int'(gnt_ch)*ADDR_W +: ADDR_W];
      mem_wdata = req_wdata[int'(gnt_ch)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (&cnt) begin
        state     <= RUN;
        init_done <= 1'b1;
      end
    end
  end

  // Tag pipe is aligned to RAM read latency; stage RD_LAT lines up with mem_rdata.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[1]    <= accept;
      tag_pipe[1].we <= req_we[gnt_ch];
      tag_pipe[1].ch <= gnt_ch;
      for (int k = 2; k <= RD_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  assign rsp_rdata = (vld_pipe[RD_LAT] && !tag_pipe[RD_LAT].we) ? mem_rdata : '0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    cpu_mem_arb_lane #(.CW(CW), .LANE(i)) u_lane (
      .accept  (accept),
      .gnt_ch  (gnt_ch),
      .tag_vld (vld_pipe[RD_LAT]),
      .tag_ch  (tag_pipe[RD_LAT].ch),
      .ready   (req_ready[i]),
      .rsp     (rsp_valid[i])
    );
  end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter (NUM_CH=2, ADDR_W=4, DATA_W=32, RD_LAT=2) with a behavioural RAM model.
module tb_cpu_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_we, init_done;
  logic [3:0]  mem_addr;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(.NUM_CH(2), .ADDR_W(4), .DATA_W(32), .RD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .init_done(init_done)
  );

  // Two-cycle write-first RAM; nonzero power-up contents make the zero-fill observable.
  logic [31:0] ram [16] = '{default: 32'hA5A5_5A5A};
  logic [31:0] rd1, rd2;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        rd1           <= mem_wdata;
      end else begin
        rd1 <= ram[mem_addr];
      end
    end
    rd2 <= rd1;
  end
  assign mem_rdata = rd2;

  typedef struct {
    logic [1:0]  v, w;
    logic [3:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  rdy, rsp;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [1:0] v, w, input logic [3:0] a0, a1,
                     input logic [31:0] d0, d1, input logic [1:0] rdy, rsp,
                     input logic [31:0] rd);
    vec_t t;
    t.v = v; t.w = w; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
    t.rdy = rdy; t.rsp = rsp; t.rd = rd;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  task automatic drive(input logic [1:0] v, w, input logic [3:0] a0, a1,
                       input logic [31:0] d0, d1);
    req_valid = v;
    req_we    = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  // Called at the negedge right after rst_n is released; returns at the negedge of cycle 17.
  task automatic sweep();
    for (int k = 0; k < 16; k++) begin
      #1;
      chk($sformatf("init%0d mem_en", k), 32'(mem_en), 32'd1);
      chk($sformatf("init%0d mem_we", k), 32'(mem_we), 32'd1);
      chk($sformatf("init%0d mem_addr", k), 32'(mem_addr), 32'(k));
      chk($sformatf("init%0d mem_wdata", k), mem_wdata, 32'd0);
      chk($sformatf("init%0d req_ready", k), 32'(req_ready), 32'd0);
      chk($sformatf("init%0d init_done", k), 32'(init_done), 32'd0);
      chk($sformatf("init%0d rsp_valid", k), 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [1:0] g [4];

    //   v      w      a0 a1 d0            d1     rdy    rsp    rdata
    add(2'b01, 2'b00, 5, 0, 0,            0,     2'b01, 2'b00, 0);
    add(2'b00, 2'b00, 0, 0, 0,            0,     2'b00, 2'b01, 0);
    add(2'b00, 2'b00, 0, 0, 0,            0,     2'b00, 2'b01, 0);
    add(2'b01, 2'b01, 3, 0, 32'hDEADBEEF, 0,     2'b01, 2'b00, 0);
    add(2'b01, 2'b00, 3, 0, 0,            0,     2'b01, 2'b00, 0);
    add(2'b00, 2'b00, 0, 0, 0,            0,     2'b00, 2'b01, 0);
    add(2'b00, 2'b00, 0, 0, 0,            0,     2'b00, 2'b01, 32'hDEADBEEF);
    add(2'b00, 2'b00, 0, 0, 0,            0,     2'b00, 2'b00, 0);
    add(2'b10, 2'b10, 0, 1, 0,            'h11,  2'b10, 2'b00, 0);
    add(2'b10, 2'b10, 0, 2, 0,            'h22,  2'b10, 2'b00, 0);
    add(2'b10, 2'b10, 0, 3, 0,            'h33,  2'b10, 2'b10, 0);
    add(2'b10, 2'b00, 0, 1, 0,            0,     2'b10, 2'b10, 0);
    add(2'b10, 2'b00, 0, 2, 0,            0,     2'b10, 2'b10, 0);
    add(2'b10, 2'b00, 0, 3, 0,            0,     2'b10, 2'b10, 'h11);
    add(2'b00, 2'b00, 0, 0, 0,            0,     2'b00, 2'b10, 'h22);
    add(2'b00, 2'b00, 0, 0, 0,            0,     2'b00, 2'b10, 'h33);
    add(2'b00, 2'b00, 0, 0, 0,            0,     2'b00, 2'b00, 0);
    add(2'b11, 2'b00, 2, 1, 0,            0,     2'b01, 2'b00, 0);
    add(2'b10, 2'b00, 0, 1, 0,            0,     2'b10, 2'b00, 0);
    add(2'b00, 2'b00, 0, 0, 0,            0,     2'b00, 2'b01, 'h22);
    add(2'b00, 2'b00, 0, 0, 0,            0,     2'b00, 2'b10, 'h11);
    add(2'b00, 2'b00, 0, 0, 0,            0,     2'b00, 2'b00, 0);

    // Reset with both channels requesting.
    rst_n = 1'b0;
    drive(2'b11, 2'b00, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst mem_en", 32'(mem_en), 32'd0);
    chk("rst init_done", 32'(init_done), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep();
    #1;
    chk("init_done rise", 32'(init_done), 32'd1);
    chk("first grant", 32'(req_ready), 32'd1);
    @(negedge clk);

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].v, tbl[r].w, tbl[r].a0, tbl[r].a1, tbl[r].d0, tbl[r].d1);
      #1;
      chk($sformatf("row%0d req_ready", r), 32'(req_ready), 32'(tbl[r].rdy));
      chk($sformatf("row%0d rsp_valid", r), 32'(rsp_valid), 32'(tbl[r].rsp));
      if (tbl[r].rsp != 2'b00)
        chk($sformatf("row%0d rsp_rdata", r), rsp_rdata, tbl[r].rd);
      @(negedge clk);
    end

    // Both channels read continuously: arbitration policy decides the grant order.
    for (int i = 0; i < 4; i++) begin
`ifdef CPU_MEM_RR_EN
      g[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      g[i] = 2'b01;
`endif
    end
    for (int i = 0; i < 6; i++) begin
      drive((i < 4) ? 2'b11 : 2'b00, 2'b00, 2, 1, 0, 0);
      #1;
      chk($sformatf("arb%0d req_ready", i), 32'(req_ready), (i < 4) ? 32'(g[i]) : 32'd0);
      chk($sformatf("arb%0d rsp_valid", i), 32'(rsp_valid), (i >= 2) ? 32'(g[i-2]) : 32'd0);
      if (i >= 2)
        chk($sformatf("arb%0d rsp_rdata", i), rsp_rdata, (g[i-2] == 2'b01) ? 32'h22 : 32'h11);
      @(negedge clk);
    end

    // Reset with two reads in flight.
    drive(2'b01, 2'b00, 2, 0, 0, 0);
    #1;
    chk("mid read0 ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    drive(2'b10, 2'b00, 0, 1, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    drive(2'b00, 2'b00, 0, 0, 0, 0);
    for (int h = 0; h < 2; h++) begin
      #1;
      chk($sformatf("mid rst%0d rsp_valid", h), 32'(rsp_valid), 32'd0);
      chk($sformatf("mid rst%0d init_done", h), 32'(init_done), 32'd0);
      chk($sformatf("mid rst%0d mem_en", h), 32'(mem_en), 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    sweep();
    drive(2'b01, 2'b00, 2, 0, 0, 0);
    #1;
    chk("rerun init_done", 32'(init_done), 32'd1);
    chk("rerun req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    drive(2'b00, 2'b00, 0, 0, 0, 0);
    #1;
    chk("rerun rsp early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("rerun rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rerun rezeroed", rsp_rdata, 32'd0);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
